// File: rtl/cell_ctrl_chain.sv
// Cell control chain: call/return handshake FSM plus an instruction load chain.
// Ports: clk, rst_n, call_in/call_out/local_call, ret_src/ret_in/ret_out,
//   busy, err, instr_*_in -> instr_*_out forward, local_instr_* write.
// Optional macro CELL_CTRL_LOAD_LOCK_EN: drop local loads while busy, flag err.
module cell_ctrl_chain #(
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int NUM_RET_SRC      = 2,
  parameter int CALL_DELAY       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        call_in,
  output logic                        call_out,
  output logic                        local_call,
  input  logic [NUM_RET_SRC-1:0]      ret_src,
  input  logic                        ret_in,
  output logic                        ret_out,
  output logic                        busy,
  output logic                        err,
  input  logic [INSTR_DATA_WIDTH-1:0] instr_data_in,
  input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_in,
  input  logic [INSTR_HOPS_WIDTH-1:0] instr_hops_in,
  input  logic                        instr_en_in,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        instr_en_out,
  output logic [INSTR_DATA_WIDTH-1:0] local_instr_data,
  output logic [INSTR_ADDR_WIDTH-1:0] local_instr_addr,
  output logic                        local_instr_en
);

  localparam int NF = NUM_RET_SRC + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NF-1:0]         flags_q, flags_d;
  logic [NF-1:0]         flags_set;
  logic [CALL_DELAY-1:0] csr_q, csr_d;
  logic                  lcall_q, lcall_d;
  logic                  ret_q, ret_d;
  logic                  err_q, err_d;

  logic [INSTR_DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic [INSTR_ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [INSTR_HOPS_WIDTH-1:0] fhops_q, fhops_d;
  logic                        fen_q, fen_d;
  logic [INSTR_DATA_WIDTH-1:0] ldata_q, ldata_d;
  logic [INSTR_ADDR_WIDTH-1:0] laddr_q, laddr_d;
  logic                        len_q, len_d;

  logic busy_w;
  logic hops_zero;
  logic ld_local;
  logic ld_fwd;
  logic ld_drop;

  assign busy_w    = (state_q != S_IDLE);
  assign flags_set = flags_q | {ret_in, ret_src};
  assign hops_zero = (instr_hops_in == '0);

`ifdef CELL_CTRL_LOAD_LOCK_EN
  assign ld_drop = instr_en_in & hops_zero & busy_w;
`else
  assign ld_drop = 1'b0;
`endif

  assign ld_local = instr_en_in & hops_zero & ~ld_drop;
  assign ld_fwd   = instr_en_in & ~hops_zero;

  // DONE spans two cycles: the first arms ret_q, the second
  // presents it on ret_out and then falls back to IDLE.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    ret_d   = 1'b0;
    lcall_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (call_in) begin
          state_d = S_RUN;
          flags_d = '0;
          lcall_d = 1'b1;
        end
      end
      S_RUN: begin
        flags_d = flags_set;
        if (&flags_set) state_d = S_DONE;
      end
      S_DONE: begin
        if (ret_q) state_d = S_IDLE;
        else       ret_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (call_in && busy_w) err_d = 1'b1;
    if (ld_drop)           err_d = 1'b1;
  end

  // Every call_in travels down the delay line, accepted or not.
  always_comb begin
    csr_d[0] = call_in;
    for (int i = 1; i < CALL_DELAY; i++) begin
      csr_d[i] = csr_q[i-1];
    end
  end

  always_comb begin
    fen_d   = ld_fwd;
    fdata_d = ld_fwd ? instr_data_in : '0;
    faddr_d = ld_fwd ? instr_addr_in : '0;
    fhops_d = ld_fwd ? (instr_hops_in - INSTR_HOPS_WIDTH'(1)) : '0;
    len_d   = ld_local;
    ldata_d = ld_local ? instr_data_in : '0;
    laddr_d = ld_local ? instr_addr_in : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      csr_q   <= '0;
      lcall_q <= 1'b0;
      ret_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      csr_q   <= csr_d;
      lcall_q <= lcall_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fen_q   <= 1'b0;
      fdata_q <= '0;
      faddr_q <= '0;
      fhops_q <= '0;
      len_q   <= 1'b0;
      ldata_q <= '0;
      laddr_q <= '0;
    end else begin
      fen_q   <= fen_d;
      fdata_q <= fdata_d;
      faddr_q <= faddr_d;
      fhops_q <= fhops_d;
      len_q   <= len_d;
      ldata_q <= ldata_d;
      laddr_q <= laddr_d;
    end
  end

  assign call_out         = csr_q[CALL_DELAY-1];
  assign local_call       = lcall_q;
  assign ret_out          = ret_q;
  assign busy             = busy_w;
  assign err              = err_q;
  assign instr_data_out   = fdata_q;
  assign instr_addr_out   = faddr_q;
  assign instr_hops_out   = fhops_q;
  assign instr_en_out     = fen_q;
  assign local_instr_data = ldata_q;
  assign local_instr_addr = laddr_q;
  assign local_instr_en   = len_q;

endmodule

// File: doc/cell_ctrl_chain.md
CELL_CTRL_CHAIN -- requirements
Module: cell_ctrl_chain

Interface
REQ-001 SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter INSTR_ADDR_WIDTH, default 6, instruction memory address width.
REQ-003 SHALL have parameter INSTR_HOPS_WIDTH, default 4, hop-count width.
REQ-004 SHALL have parameter NUM_RET_SRC, default 2, range 1..16, number of local return sources.
REQ-005 SHALL have parameter CALL_DELAY, default 1, range 1..8, call_out latency in cycles.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk, rst_n.
REQ-007 Ports (name direction width meaning):
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 call_in  in  1  single-cycle call pulse from upstream cell
 call_out  out  1  call pulse to downstream cell
 local_call  out  1  call pulse to local sequencer
 ret_src  in  NUM_RET_SRC  local return pulses, one per source
 ret_in  in  1  return pulse from downstream cell
 ret_out  out  1  aggregated return pulse to upstream
 busy  out  1  high while not IDLE
 err  out  1  sticky protocol error
 instr_data_in / instr_addr_in / instr_hops_in / instr_en_in  in  INSTR_DATA_WIDTH / INSTR_ADDR_WIDTH / INSTR_HOPS_WIDTH / 1  load chain input
 instr_data_out / instr_addr_out / instr_hops_out / instr_en_out  out  same widths  load chain forward
 local_instr_data / local_instr_addr / local_instr_en  out  INSTR_DATA_WIDTH / INSTR_ADDR_WIDTH / 1  local instruction write

Function
REQ-008 FSM states: IDLE, RUN, DONE.
REQ-009 IDLE + call_in=1 SHALL go to RUN next cycle, clearing all NUM_RET_SRC+1 sticky return flags.
REQ-010 local_call SHALL pulse 1 cycle after the accepted call_in; call_out SHALL pulse exactly CALL_DELAY cycles after call_in (shift register, every call_in propagated).
REQ-011 In RUN, ret_src[i]=1 SHALL set flag i; ret_in=1 SHALL set the downstream flag; flags hold until next accepted call.
REQ-012 Return pulses in the same cycle as the accepted call_in SHALL be discarded.
REQ-013 RUN with all flags set (including those set this cycle) SHALL go to DONE; DONE SHALL drive ret_out=1 for exactly one cycle, then return to IDLE.
REQ-014 call_in in RUN or DONE SHALL be ignored for the FSM and set err; return pulses in IDLE or DONE SHALL be ignored.
REQ-015 busy = (state != IDLE), registered-state decode.
REQ-016 instr_en_in=1 with instr_hops_in=0 SHALL register a local write: local_instr_en=1, data/addr captured, 1-cycle latency.
REQ-017 instr_en_in=1 with instr_hops_in>0 SHALL forward next cycle: instr_en_out=1, data/addr unchanged, instr_hops_out=instr_hops_in-1; no wrap possible.
REQ-018 Cycles without a load SHALL drive instr_en_out=0, local_instr_en=0 and zero all instr_*_out and local_instr_data/addr.
REQ-019 Back-to-back loads every cycle SHALL be sustained with no bubbles or drops.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, clear flags, call shift register and err, and drive every output to 0.
REQ-021 Reset mid-RUN SHALL abort the call with no ret_out; in-flight call_out/local_call pulses SHALL be lost.
REQ-022 Outputs SHALL change only on posedge clk after rst_n deasserts.

Configuration
REQ-023 Macro CELL_CTRL_LOAD_LOCK_EN: when defined, a hops=0 load arriving while busy=1 SHALL be dropped (local_instr_en stays 0) and SHALL set err; forwarded loads unaffected.
REQ-024 Without CELL_CTRL_LOAD_LOCK_EN, local loads SHALL be accepted in every state and never set err.

Verification
REQ-025 NUM_RET_SRC=2, CALL_DELAY=3: call_in at cycle 0 -> local_call at 1, call_out at 3, busy=1 from 1.
REQ-026 In RUN pulse ret_src[0] at 5, ret_in at 7, ret_src[1] at 9 -> ret_out=1 at cycle 11 only, busy=0 at 12.
REQ-027 Load hops=2, addr=0x05, data=0xDEADBEEF -> next cycle instr_en_out=1, hops_out=1, same addr/data; local_instr_en=0.
REQ-028 Load hops=0, addr=0x3F, data=0x1 during RUN -> with macro: dropped, err=1; without: local_instr_en=1, addr=0x3F, data=0x1.
REQ-029 rst_n low in RUN after one ret_src -> all outputs 0 immediately; new call needs all returns again; second call_in in RUN -> err=1, no restart.
